mat_row_rr_arb: RTL and testbench
=================================

Name: mat_row_rr_arb

Overview:
- Shares the single matrix row-read port between NUM_REQ compute engines (triangular inverse, substitution, etc.) with round-robin arbitration.
- Each requester issues a row address with valid/ready. The arbiter drives the row store's addr/valid pair and receives the registered row MEM_LAT cycles later.
- It returns that row to the owning requester with a one-hot valid.
- It sits between the engines' mat_row_addr_o/mat_row_addr_valid_o outputs and the row store that feeds mat_row_i/mat_row_valid_i.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..8)
- SIZE, 8, matrix dimension; rows are 0..SIZE-1
- WIDTH, 64, bits per real/imag component; a row element is {imag,real}, 2*WIDTH bits
- MEM_LAT, 1, row store read latency in cycles (1..4)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester row request
- req_addr_i  in  NUM_REQ x $clog2(SIZE)  per-requester row address
- req_lock_i  in  NUM_REQ  keep grant for the next request (used only with ARB_LOCK_EN)
- req_ready_o  out  NUM_REQ  one-hot grant; transfer when valid&ready
- mem_addr_o  out  $clog2(SIZE)  row address to store
- mem_valid_o  out  1  row read strobe
- mem_row_i  in  SIZE x 2*WIDTH  row data from store, MEM_LAT cycles after strobe
- rsp_row_o  out  SIZE x 2*WIDTH  returned row (shared bus)
- rsp_addr_o  out  $clog2(SIZE)  address of returned row
- rsp_valid_o  out  NUM_REQ  one-hot owner of returned row
- flush_i  in  1  synchronous abort of all in-flight reads
- busy_o  out  1  any request pending or read in flight

Behaviour:
- Reset (async, rst_ni=0): req_ready_o=0, mem_valid_o=0, mem_addr_o=0, rsp_valid_o=0, rsp_addr_o=0, busy_o=0, RR pointer=NUM_REQ-1 (requester 0 highest first), lock cleared, tag pipeline cleared.
- Arbitration is combinational each cycle. Search req_valid_i starting at pointer+1 mod NUM_REQ. The first hit gets req_ready_o. At most one bit of req_ready_o is set. No ready without valid.
- Handshake at edge E (valid&ready):
  - pointer <= granted index.
  - mem_addr_o/mem_valid_o are registered and high for exactly the cycle after E.
  - {id, addr} enter a MEM_LAT-deep tag shift register.
- Response:
  - rsp_valid_o[id] is asserted in the cycle the tag exits (E+1+MEM_LAT, i.e. 2 cycles after E for MEM_LAT=1).
  - rsp_row_o = mem_row_i passes through combinationally.
  - rsp_addr_o comes from the tag.
  - rsp_valid_o=0 on all other cycles. rsp_row_o is don't-care when rsp_valid_o=0.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants to different requesters are allowed, and responses return in grant order.
- Requester rule: hold req_valid_i and req_addr_i stable until ready. Dropping valid before ready withdraws the request with no side effect.
- flush_i=1 (synchronous, same edge):
  - req_ready_o forced 0 that cycle.
  - Tag pipeline and mem_valid_o cleared, so a store response arriving later is dropped and produces no rsp_valid_o.
  - Pointer reset to NUM_REQ-1 and lock cleared.
  - Arbitration resumes the cycle after flush deasserts.
- busy_o = |req_valid_i | mem_valid_o | any tag valid. It is registered except for the req_valid_i term.
- Reset mid-operation discards everything immediately. No response is emitted for pre-reset grants.

Optional Feature:
- ARB_LOCK_EN defined:
  - If a grant to k completes with req_lock_i[k]=1, k keeps priority. The next arbitration grants k whenever req_valid_i[k]=1, ignoring round-robin.
  - The lock releases on a grant with req_lock_i[k]=0, on a cycle where req_valid_i[k]=0 while locked, or on flush.
  - Purpose: a sequential row sweep of the triangular inverse runs unbroken.
- ARB_LOCK_EN undefined: req_lock_i is ignored and pure round-robin applies. The port remains present.

Test Plan:
- Single request: req0 valid, addr=5, others idle -> ready0 same cycle; mem_valid_o=1, mem_addr_o=5 next cycle; rsp_valid_o=4'b0001, rsp_addr_o=5, rsp_row_o=row5 two cycles after grant; busy_o then 0.
- All four requesting continuously, addr=k for requester k -> grants 0,1,2,3,0,... one per cycle; rsp_valid_o sequence 0001,0010,0100,1000 with rsp_addr_o 0,1,2,3.
- MEM_LAT=3, req2 addr=7 -> rsp_valid_o=4'b0100 exactly 4 cycles after grant, row7 data.
- Grant req1 addr=3, then flush_i=1 the next cycle -> no rsp_valid_o ever for that read, req_ready_o=0 during flush, and the next grant after flush goes to the lowest-index valid requester.
- With ARB_LOCK_EN, req0 lock=1 sweeping addr 0..7 while req1 is valid -> eight consecutive grants to req0, then req1 on the grant after the lock=0 request. Without the macro, grants alternate 0,1,0,1.
- Assert rst_ni=0 with 2 reads in flight -> all outputs 0 immediately and no responses after reset release.

Source files
------------

// File: rtl/mat_row_rr_arb.sv
// Round-robin arbiter sharing one matrix row-read port between NUM_REQ engines.
// Optional grant locking for unbroken row sweeps is enabled by defining ARB_LOCK_EN.
module mat_row_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 8,
    parameter int WIDTH   = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_REQ-1:0]                       req_valid_i,
    input  logic [NUM_REQ-1:0][$clog2(SIZE)-1:0]     req_addr_i,
    input  logic [NUM_REQ-1:0]                       req_lock_i,
    output logic [NUM_REQ-1:0]                       req_ready_o,
    output logic [$clog2(SIZE)-1:0]                  mem_addr_o,
    output logic                                     mem_valid_o,
    input  logic [SIZE-1:0][2*WIDTH-1:0]             mem_row_i,
    output logic [SIZE-1:0][2*WIDTH-1:0]             rsp_row_o,
    output logic [$clog2(SIZE)-1:0]                  rsp_addr_o,
    output logic [NUM_REQ-1:0]                       rsp_valid_o,
    input  logic                                     flush_i,
    output logic                                     busy_o
);

    localparam int AW  = $clog2(SIZE);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]               r_ptr;
    logic                         w_gnt_vld;
    logic [IDW-1:0]               w_gnt_id;
    logic                         w_lock_hit;
    logic [IDW-1:0]               w_lock_id;

    logic                         r_mem_vld;
    logic [AW-1:0]                r_mem_addr;
    logic [IDW-1:0]               r_mem_id;

    logic [MEM_LAT-1:0]           r_tag_vld;
    logic [MEM_LAT-1:0][IDW-1:0]  r_tag_id;
    logic [MEM_LAT-1:0][AW-1:0]   r_tag_addr;

`ifdef ARB_LOCK_EN
    logic                         r_lock_vld;
    logic [IDW-1:0]               r_lock_id;

    assign w_lock_hit = r_lock_vld && req_valid_i[r_lock_id];
    assign w_lock_id  = r_lock_id;

    // Lock follows the last grant's lock bit; it drops once its owner goes idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
        end else if (flush_i) begin
            r_lock_vld <= 1'b0;
        end else if (w_gnt_vld) begin
            r_lock_vld <= req_lock_i[w_gnt_id];
            r_lock_id  <= w_gnt_id;
        end else if (r_lock_vld && !req_valid_i[r_lock_id]) begin
            r_lock_vld <= 1'b0;
        end
    end
`else
    logic w_unused_lock;

    assign w_lock_hit    = 1'b0;
    assign w_lock_id     = '0;
    assign w_unused_lock = ^req_lock_i;
`endif

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        logic [IDW-1:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_gnt_vld && req_valid_i[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
        if (w_lock_hit) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_lock_id;
        end
        if (flush_i || !rst_ni) begin
            w_gnt_vld = 1'b0;
        end
    end

    // Store strobe stage, then MEM_LAT tag stages aligned with the store's row return.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= PTR_RST;
            r_mem_vld  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_id   <= '0;
            r_tag_vld  <= '0;
            r_tag_id   <= '0;
            r_tag_addr <= '0;
        end else begin
            r_mem_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_mem_addr <= req_addr_i[w_gnt_id];
                r_mem_id   <= w_gnt_id;
            end
            r_tag_vld[0]  <= r_mem_vld && !flush_i;
            r_tag_id[0]   <= r_mem_id;
            r_tag_addr[0] <= r_mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1] && !flush_i;
                r_tag_id[i]   <= r_tag_id[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
            if (flush_i) begin
                r_ptr <= PTR_RST;
            end else if (w_gnt_vld) begin
                r_ptr <= w_gnt_id;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (w_gnt_vld) begin
            req_ready_o[w_gnt_id] = 1'b1;
        end
        rsp_valid_o = '0;
        if (r_tag_vld[MEM_LAT-1]) begin
            rsp_valid_o[r_tag_id[MEM_LAT-1]] = 1'b1;
        end
    end

    assign mem_valid_o = r_mem_vld;
    assign mem_addr_o  = r_mem_addr;
    assign rsp_addr_o  = r_tag_addr[MEM_LAT-1];
    assign rsp_row_o   = mem_row_i;
    assign busy_o      = rst_ni && ((|req_valid_i) || r_mem_vld || (|r_tag_vld));

endmodule

// File: tb/tb_mat_row_rr_arb.sv
// Testbench for mat_row_rr_arb: directed scenarios plus randomized traffic
// against a queue-based reference model of grants and returned rows.
`timescale 1ns/1ps
module tb_mat_row_rr_arb;

    localparam int NUM_REQ = 4;
    localparam int SIZE    = 8;
    localparam int WIDTH   = 16;
    localparam int MEM_LAT = 1;
    localparam int AW      = $clog2(SIZE);

    typedef logic [SIZE-1:0][2*WIDTH-1:0] row_t;
    typedef struct {
        int due;
        int id;
        int addr;
    } tag_t;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][AW-1:0]        req_addr;
    logic [NUM_REQ-1:0]                req_lock;
    logic [NUM_REQ-1:0]                req_ready;
    logic [AW-1:0]                     mem_addr;
    logic                              mem_valid;
    row_t                              mem_row;
    row_t                              rsp_row;
    logic [AW-1:0]                     rsp_addr;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic                              flush;
    logic                              busy;

    int errors = 0;
    int checks = 0;

    row_t          rows [SIZE];
    logic [AW-1:0] st_a [MEM_LAT];

    always #5 clk = ~clk;

    mat_row_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .SIZE    (SIZE),
        .WIDTH   (WIDTH),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_lock_i  (req_lock),
        .req_ready_o (req_ready),
        .mem_addr_o  (mem_addr),
        .mem_valid_o (mem_valid),
        .mem_row_i   (mem_row),
        .rsp_row_o   (rsp_row),
        .rsp_addr_o  (rsp_addr),
        .rsp_valid_o (rsp_valid),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    // Behavioural row store: registered read with MEM_LAT cycles of latency.
    always @(posedge clk) begin
        st_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            st_a[i] <= st_a[i-1];
        end
    end
    assign mem_row = rows[st_a[MEM_LAT-1]];

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_lock  = '0;
        flush     = 1'b0;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        checks++; if ({mem_valid, mem_addr} !== '0) begin errors++; $display("FAIL reset_mem got=%b/%0d exp=0/0", mem_valid, mem_addr); end
        checks++; if ({rsp_valid, rsp_addr} !== '0) begin errors++; $display("FAIL reset_rsp got=%b/%0d exp=0/0", rsp_valid, rsp_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_valid   = 4'b0001;
        req_addr[0] = AW'(5);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_req got=%b exp=1", busy); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if ({mem_valid, mem_addr} !== {1'b1, AW'(5)}) begin errors++; $display("FAIL single_mem got=%b/%0d exp=1/5", mem_valid, mem_addr); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL single_rsp_early got=%b exp=0", rsp_valid); end
        repeat (MEM_LAT - 1) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL single_rsp_wait got=%b exp=0", rsp_valid); end
        end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_addr !== AW'(5)) begin errors++; $display("FAIL single_rsp got=%b/%0d exp=0001/5", rsp_valid, rsp_addr); end
        checks++; if (rsp_row !== rows[5]) begin errors++; $display("FAIL single_row got=%h exp=%h", rsp_row, rows[5]); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_mem_once got=%b exp=0", mem_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b/%b exp=0000/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_rsp;
        int r;
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++) req_addr[k] = AW'(k);
        for (int c = 0; c < 8 + 1 + MEM_LAT; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? '1 : '0;
            #1;
            exp_rdy = '0;
            if (c < 8) exp_rdy[c % NUM_REQ] = 1'b1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            r = c - 1 - MEM_LAT;
            exp_rsp = '0;
            if (r >= 0 && r < 8) exp_rsp[r % NUM_REQ] = 1'b1;
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
            if (exp_rsp != '0) begin
                checks++; if (rsp_addr !== AW'(r % NUM_REQ) || rsp_row !== rows[r % NUM_REQ]) begin
                    errors++; $display("FAIL rr_data c=%0d got=%0d exp=%0d", c, rsp_addr, r % NUM_REQ);
                end
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        req_addr[0] = AW'(6);
        req_addr[1] = AW'(3);
        req_addr[3] = AW'(4);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL flush_pre_ready got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1001;
        flush     = 1'b1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
        checks++; if ({mem_valid, mem_addr} !== {1'b1, AW'(3)}) begin errors++; $display("FAIL flush_mem got=%b/%0d exp=1/3", mem_valid, mem_addr); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_next_grant got=%b exp=0001", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_mem_clr got=%b exp=0", mem_valid); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL flush_rsp_drop got=%b exp=0000", rsp_valid); end
        for (int c = 0; c < MEM_LAT + 2; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (c == MEM_LAT) begin
                checks++; if (rsp_valid !== 4'b0001 || rsp_addr !== AW'(6) || rsp_row !== rows[6]) begin
                    errors++; $display("FAIL flush_after_rsp got=%b/%0d exp=0001/6", rsp_valid, rsp_addr);
                end
            end else begin
                checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL flush_quiet c=%0d got=%b exp=0000", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_lock();
        logic [NUM_REQ-1:0] exp_rdy;
        int a0;
        apply_reset();
        a0          = 0;
        req_addr[1] = AW'(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid    = '0;
            req_valid[0] = (a0 < 8);
            req_valid[1] = 1'b1;
            req_addr[0]  = AW'(a0 % SIZE);
            req_lock     = '0;
            req_lock[0]  = (a0 < 7);
            #1;
`ifdef ARB_LOCK_EN
            exp_rdy = (c < 8) ? 4'b0001 : 4'b0010;
`else
            exp_rdy = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL lock_seq c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            if (exp_rdy[0]) a0++;
        end
        @(negedge clk);
        req_valid = '0;
        req_lock  = '0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_addr[0] = AW'(1);
        req_addr[1] = AW'(2);
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_g0 got=%b exp=0001", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_g1 got=%b exp=0010", req_ready); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got=%b/%b exp=0000/0", req_ready, busy); end
        checks++; if ({mem_valid, mem_addr, rsp_valid, rsp_addr} !== '0) begin
            errors++; $display("FAIL rstmid_out got=%b/%0d/%b/%0d exp=0/0/0000/0", mem_valid, mem_addr, rsp_valid, rsp_addr);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < MEM_LAT + 3; c++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== '0 || mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet c=%0d got=%b/%b exp=0000/0", c, rsp_valid, mem_valid); end
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        int                 paddr [NUM_REQ];
        logic [NUM_REQ-1:0] plock;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_rsp;
        tag_t               q [$];
        tag_t               t;
        int ptr, g, j, cyc, m_a, lk_id, exp_a;
        bit m_v, lk_v, exp_busy;
        apply_reset();
        pend  = '0;
        plock = '0;
        for (int k = 0; k < NUM_REQ; k++) paddr[k] = 0;
        ptr = NUM_REQ - 1; cyc = 0; m_v = 0; m_a = 0; lk_v = 0; lk_id = 0; exp_a = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        pend[k]  = 1'b1;
                        paddr[k] = int'($urandom_range(0, SIZE - 1));
                        plock[k] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    pend[k] = 1'b0;
                end
                req_addr[k] = AW'(paddr[k]);
            end
            req_valid = pend;
            req_lock  = plock;
            flush     = ($urandom_range(0, 99) < 4);
            #1;
            g = -1;
            if (!flush) begin
`ifdef ARB_LOCK_EN
                if (lk_v && pend[lk_id]) g = lk_id;
`endif
                for (int i = 1; i <= NUM_REQ; i++) begin
                    j = (ptr + i) % NUM_REQ;
                    if (g < 0 && pend[j]) g = j;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            checks++; if (mem_valid !== m_v || (m_v && mem_addr !== AW'(m_a))) begin
                errors++; $display("FAIL rnd_mem cyc=%0d got=%b/%0d exp=%b/%0d", cyc, mem_valid, mem_addr, m_v, m_a);
            end
            exp_busy = (pend != '0) || (q.size() > 0);
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            exp_rsp = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                t = q.pop_front();
                exp_rsp[t.id] = 1'b1;
                exp_a = t.addr;
            end
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp); end
            if (exp_rsp != '0) begin
                checks++; if (rsp_addr !== AW'(exp_a) || rsp_row !== rows[exp_a]) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", cyc, rsp_addr, exp_a);
                end
            end
            m_v = (g >= 0);
            if (g >= 0) m_a = paddr[g];
            if (flush) begin
                ptr  = NUM_REQ - 1;
                lk_v = 0;
                q.delete();
            end else if (g >= 0) begin
                ptr = g;
                t.due = cyc + 1 + MEM_LAT; t.id = g; t.addr = paddr[g];
                q.push_back(t);
                lk_v    = plock[g];
                lk_id   = g;
                pend[g] = 1'b0;
            end else if (lk_v && !pend[lk_id]) begin
                lk_v = 0;
            end
            cyc++;
        end
        @(negedge clk);
        req_valid = '0;
        flush     = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < SIZE; a++) begin
            for (int e = 0; e < SIZE; e++) begin
                rows[a][e] = (2*WIDTH)'($urandom);
            end
        end
        for (int i = 0; i < MEM_LAT; i++) st_a[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_flush();
        test_lock();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
